// File: rtl/sha3_absorb_loader.sv
// rtl/sha3_absorb_loader.sv - SHA-3 lane loader: pads the message and XORs rate blocks into the chained state
// Optional feature macro: SHA3_ABSORB_LOADER_STALL_CNT_EN (builds the ostall_cnt input-stall counter)
module sha3_absorb_loader #(
  parameter int         RATE_LANES = 17,
  parameter logic [7:0] DOMAIN_PAD = 8'h06
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [63:0]     idata,
  input  logic            ivalid,
  input  logic            ilast,
  input  logic [3:0]      ibytes,
  output logic            iready,
  input  logic [4:0][63:0] icha,
  input  logic [4:0][63:0] ichb,
  input  logic [4:0][63:0] ichc,
  input  logic [4:0][63:0] ichd,
  input  logic [4:0][63:0] iche,
  input  logic            ichain_good,
  output logic [4:0][63:0] osa,
  output logic [4:0][63:0] osb,
  output logic [4:0][63:0] osc,
  output logic [4:0][63:0] osd,
  output logic [4:0][63:0] ose,
  output logic            ogood,
  output logic            ofinal,
  output logic [31:0]     ostall_cnt
);

  generate
    if (!(RATE_LANES == 9 || RATE_LANES == 13 || RATE_LANES == 17 || RATE_LANES == 18)) begin : g_bad_rate
      $error("sha3_absorb_loader: RATE_LANES must be 9, 13, 17 or 18");
    end
  endgenerate

  typedef enum logic [1:0] {FILL, EMIT, WAIT_CHAIN, PADBLK} state_t;

  localparam logic [4:0] K_LAST = 5'(RATE_LANES - 1);

  state_t                      state, state_nxt;
  logic [RATE_LANES-1:0][63:0] block, blk_nxt, last_blk, pad_blk;
  logic [24:0][63:0]           cap, os_q, blk_ext, st;
  logic [4:0]                  k;
  logic                        extra_pend;
  logic                        accept;
  logic [3:0]                  n;
  logic [63:0]                 lane_mask, lane_pad;
  logic                        ext_pad;
  logic                        fin_nxt;

  assign iready = rst_n && (state == FILL);
  assign accept = ivalid && iready;

  assign osa = os_q[4:0];
  assign osb = os_q[9:5];
  assign osc = os_q[14:10];
  assign osd = os_q[19:15];
  assign ose = os_q[24:20];

  // Final-lane block: truncate the lane, place the domain byte and the closing 0x80 bit.
  always_comb begin
    n         = (ibytes > 4'd8) ? 4'd8 : ibytes;
    lane_mask = '0;
    lane_pad  = '0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < n)  lane_mask[8*b +: 8] = 8'hFF;
      if (4'(b) == n) lane_pad[8*b +: 8]  = DOMAIN_PAD;
    end
    // A full final lane in the last slot leaves no room for padding: it goes in an extra block.
    ext_pad  = (n == 4'd8) && (k == K_LAST);
    last_blk = '0;
    for (int i = 0; i < RATE_LANES; i++) begin
      if (5'(i) < k)
        last_blk[i] = block[i];
      else if (5'(i) == k)
        last_blk[i] = (idata & lane_mask) | lane_pad;
      else if ((5'(i) == k + 5'd1) && (n == 4'd8))
        last_blk[i] = {56'h0, DOMAIN_PAD};
    end
    if (!ext_pad)
      last_blk[RATE_LANES-1][63:56] = last_blk[RATE_LANES-1][63:56] | 8'h80;
  end

  // Padding-only block used when the message filled the final rate lane exactly.
  always_comb begin
    pad_blk                       = '0;
    pad_blk[0][7:0]               = DOMAIN_PAD;
    pad_blk[RATE_LANES-1][63:56]  = pad_blk[RATE_LANES-1][63:56] | 8'h80;
  end

  // Next-state, next block contents and the ofinal qualifier for the coming EMIT.
  always_comb begin
    state_nxt = state;
    blk_nxt   = block;
    fin_nxt   = ofinal;
    case (state)
      FILL: begin
        if (accept) begin
          if (ilast) begin
            blk_nxt   = last_blk;
            state_nxt = EMIT;
            fin_nxt   = !ext_pad;
          end else begin
            for (int i = 0; i < RATE_LANES; i++)
              if (5'(i) == k) blk_nxt[i] = idata;
            if (k == K_LAST) begin
              state_nxt = EMIT;
              fin_nxt   = 1'b0;
            end
          end
        end
      end
      EMIT: begin
        blk_nxt   = '0;
        state_nxt = ofinal ? FILL : WAIT_CHAIN;
      end
      WAIT_CHAIN: begin
        if (ichain_good) state_nxt = extra_pend ? PADBLK : FILL;
      end
      PADBLK: begin
        blk_nxt   = pad_blk;
        state_nxt = EMIT;
        fin_nxt   = 1'b1;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Absorbed state: rate lanes are XORed in, capacity lanes pass the chained state through.
  always_comb begin
    blk_ext                   = '0;
    blk_ext[RATE_LANES-1:0]   = blk_nxt;
    st                        = cap ^ blk_ext;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // Lane buffer, chained state, lane counter and registered output rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block      <= '0;
      cap        <= '0;
      k          <= '0;
      extra_pend <= 1'b0;
      os_q       <= '0;
      ogood      <= 1'b0;
      ofinal     <= 1'b0;
    end else begin
      block <= blk_nxt;
      ogood <= (state_nxt == EMIT);
      if (state_nxt == EMIT) begin
        os_q   <= st;
        ofinal <= fin_nxt;
      end
      case (state)
        FILL: begin
          if (accept) begin
            if (ilast)              extra_pend <= ext_pad;
            else if (k != K_LAST)   k <= k + 5'd1;
          end
        end
        EMIT: begin
          k <= '0;
          if (ofinal) cap <= '0;
        end
        WAIT_CHAIN: begin
          if (ichain_good) cap <= {iche, ichd, ichc, ichb, icha};
        end
        PADBLK: extra_pend <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef SHA3_ABSORB_LOADER_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Count cycles a lane is offered but not taken; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (ivalid && !iready && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign ostall_cnt = stall_cnt;
`else
  assign ostall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_sha3_absorb_loader.sv
// tb/tb_sha3_absorb_loader.sv - directed self-checking bench for sha3_absorb_loader
module tb_sha3_absorb_loader;

  logic            clk;
  logic            rst_n;
  logic [63:0]     idata;
  logic            ilast;
  logic [3:0]      ibytes;
  logic            ivalid17, ivalid9;
  logic            iready17, iready9;
  logic [4:0][63:0] icha, ichb, ichc, ichd, iche;
  logic            ichain_good;
  logic [4:0][63:0] osa17, osb17, osc17, osd17, ose17;
  logic [4:0][63:0] osa9, osb9, osc9, osd9, ose9;
  logic            ogood17, ogood9, ofinal17, ofinal9;
  logic [31:0]     stall17, stall9;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] TOP  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] A5   = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] CH   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DD   = 64'hDEAD_BEEF_00C0_FFEE;

`ifdef SHA3_ABSORB_LOADER_STALL_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd4;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  sha3_absorb_loader #(.RATE_LANES(17), .DOMAIN_PAD(8'h06)) u_dut17 (
    .clk(clk), .rst_n(rst_n), .idata(idata), .ivalid(ivalid17), .ilast(ilast), .ibytes(ibytes),
    .iready(iready17), .icha(icha), .ichb(ichb), .ichc(ichc), .ichd(ichd), .iche(iche),
    .ichain_good(ichain_good), .osa(osa17), .osb(osb17), .osc(osc17), .osd(osd17), .ose(ose17),
    .ogood(ogood17), .ofinal(ofinal17), .ostall_cnt(stall17)
  );

  sha3_absorb_loader #(.RATE_LANES(9), .DOMAIN_PAD(8'h06)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .idata(idata), .ivalid(ivalid9), .ilast(ilast), .ibytes(ibytes),
    .iready(iready9), .icha(icha), .ichb(ichb), .ichc(ichc), .ichd(ichd), .iche(iche),
    .ichain_good(ichain_good), .osa(osa9), .osb(osb9), .osc(osc9), .osd(osd9), .ose(ose9),
    .ogood(ogood9), .ofinal(ofinal9), .ostall_cnt(stall9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [319:0] rep(input logic [63:0] v);
    return {5{v}};
  endfunction

  task automatic send(input bit sel9, input logic [63:0] d, input logic last, input logic [3:0] nb);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    idata  = d;
    ilast  = last;
    ibytes = nb;
    if (sel9) ivalid9 = 1'b1;
    else      ivalid17 = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (sel9 ? iready9 : iready17) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1;
    ivalid9  = 1'b0;
    ivalid17 = 1'b0;
    ilast    = 1'b0;
    check("send_accept", ok, 1'b1);
  endtask

  task automatic wait_good(input bit sel9, input string tag);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #1;
      if (sel9 ? ogood9 : ogood17) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic chain(input logic [63:0] v);
    @(negedge clk);
    icha = rep(v); ichb = rep(v); ichc = rep(v); ichd = rep(v); iche = rep(v);
    ichain_good = 1'b1;
    @(posedge clk);
    #1;
    ichain_good = 1'b0;
  endtask

  initial begin
    logic [4:0][63:0] e;
    rst_n = 1'b0; idata = '0; ilast = 1'b0; ibytes = '0;
    ivalid17 = 1'b0; ivalid9 = 1'b0; ichain_good = 1'b0;
    icha = '0; ichb = '0; ichc = '0; ichd = '0; iche = '0;

    repeat (3) @(negedge clk);
    check("rst_iready", iready17, 1'b0);
    check("rst_ogood", ogood17, 1'b0);
    check("rst_osa", osa17, '0);
    rst_n = 1'b1;
    #1;
    check("rel_iready", iready17, 1'b1);

    // Empty message
    send(1'b0, 64'h0000_0000_0000_0123, 1'b1, 4'd0);
    check("s1_ogood", ogood17, 1'b1);
    check("s1_ofinal", ofinal17, 1'b1);
    check("s1_osa", osa17, 320'h06);
    e = '0; e[1] = TOP;
    check("s1_osd", osd17, e);
    check("s1_osbce", {osb17, osc17, ose17}, '0);
    @(posedge clk); #1;
    check("s1_ogood_pulse", ogood17, 1'b0);
    check("s1_iready_back", iready17, 1'b1);

    // 3-byte message "abc"
    send(1'b0, 64'hFFFF_FFFF_FF63_6261, 1'b1, 4'd3);
    check("s2_ogood", ogood17, 1'b1);
    check("s2_osa", osa17, 320'h0000_0000_0663_6261);
    e = '0; e[1] = TOP;
    check("s2_osd", osd17, e);
    check("s2_osb", osb17, '0);

    // RATE_LANES=9, message exactly fills the block: extra padding block needed
    for (int i = 0; i < 8; i++) send(1'b1, 64'(i + 1), 1'b0, 4'd0);
    send(1'b1, 64'd9, 1'b1, 4'd8);
    check("s3_ogood", ogood9, 1'b1);
    check("s3_ofinal", ofinal9, 1'b0);
    for (int i = 0; i < 5; i++) e[i] = 64'(i + 1);
    check("s3_osa", osa9, e);
    e[0] = 64'd6; e[1] = 64'd7; e[2] = 64'd8; e[3] = 64'd9; e[4] = 64'd0;
    check("s3_osb", osb9, e);
    @(posedge clk); #1;
    check("s3_iready_wait0", iready9, 1'b0);
    @(posedge clk); #1;
    check("s3_iready_wait1", iready9, 1'b0);
    chain(64'd1);
    wait_good(1'b1, "s3_pad_ogood");
    check("s3_pad_ofinal", ofinal9, 1'b1);
    e = rep(64'd1); e[0] = 64'h07;
    check("s3_pad_osa", osa9, e);
    e = rep(64'd1); e[3] = 64'h8000_0000_0000_0001;
    check("s3_pad_osb", osb9, e);
    check("s3_pad_osc", osc9, rep(64'd1));

    // Two-block message on RATE_LANES=17, with input stalls while waiting for the chain
    for (int i = 0; i < 17; i++) send(1'b0, A5, 1'b0, 4'd0);
    check("s4_ogood", ogood17, 1'b1);
    check("s4_ofinal", ofinal17, 1'b0);
    check("s4_osa", osa17, rep(A5));
    e = '0; e[0] = A5; e[1] = A5;
    check("s4_osd", osd17, e);
    check("s4_ose", ose17, '0);
    @(posedge clk);
    @(negedge clk);
    ivalid17 = 1'b1;
    check("s4_iready_wait", iready17, 1'b0);
    repeat (4) @(negedge clk);
    ivalid17 = 1'b0;
    check("s4_stall_cnt", stall17, EXP_STALL);
    chain(CH);
    send(1'b0, DD, 1'b1, 4'd8);
    check("s4_b2_ogood", ogood17, 1'b1);
    check("s4_b2_ofinal", ofinal17, 1'b1);
    e = rep(CH); e[0] = CH ^ DD; e[1] = CH ^ 64'h06;
    check("s4_b2_osa", osa17, e);
    e = rep(CH); e[1] = CH ^ TOP;
    check("s4_b2_osd", osd17, e);
    check("s4_b2_ose", ose17, rep(CH));

    // Reset in the middle of a message
    for (int i = 0; i < 5; i++) send(1'b0, 64'h1111_1111_1111_1111, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("s5_rst_os", {osa17, osb17, osc17, osd17, ose17} == '0, 1'b1);
    check("s5_rst_flags", {ogood17, ofinal17, iready17}, 3'b000);
    check("s5_rst_stall", stall17, '0);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 64'h55, 1'b1, 4'd0);
    check("s5_ogood", ogood17, 1'b1);
    check("s5_ofinal", ofinal17, 1'b1);
    check("s5_osa", osa17, 320'h06);
    check("s5_osb", osb17, '0);
    e = '0; e[1] = TOP;
    check("s5_osd", osd17, e);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
